alu_seq: RTL and testbench

Parametrised, handshaked successor to the single-cycle execute ALU. Accepts one operation per transaction over a valid/ready input channel and returns a registered result plus flags over a valid/ready output channel. Most ops take 1 cycle; an optional iterative multiplier takes WIDTH+1 cycles. It sits between the decode/issue stage and writeback of the multi-cycle core, so execute latency can vary per operation.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_seq_mul.sv | 65 ++++++
 rtl/alu_seq.sv | 182 ++++++++++++++++++
 tb/tb_alu_seq.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode constants, FSM state type and shift-amount
//               width helper for the sequential ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  // 4-bit operation codes; 1011..1111 are reserved
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;

  // Control FSM states (MUL/DONE only reachable when the multiplier is built)
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of operand-b bits that form the shift amount
  function automatic int shamt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_mul.sv
// ============================================================================
// Module      : alu_seq_mul
// Description : Iterative shift-add multiplier, one partial product per cycle.
//               Produces the low WIDTH bits of a*b after WIDTH iterations.
//               done_o is high during the final iteration cycle; product_o
//               holds the finished value on the following cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int CNT_W = shamt_w(WIDTH);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] count_q;
  logic             busy_q;

  assign done_o    = busy_q && (count_q == CNT_W'(WIDTH - 1));
  assign product_o = acc_q;

  // Load operands on start, then add/shift once per cycle until WIDTH iterations
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
    end else if (start_i) begin
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
      count_q  <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_q <= acc_q + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      count_q  <= count_q + CNT_W'(1);
      if (done_o) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// Module      : alu_seq
// Description : Handshaked sequential ALU. Single-cycle integer ops plus an
//               optional iterative multiplier (WIDTH+1 cycle latency).
//               Build option: define ALU_MUL_EN to include the multiplier;
//               otherwise opcode 1010 behaves as reserved.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             sign_o,
  output logic             carry_o,
  output logic             ovf_o
);

  localparam int SHAMT_W = shamt_w(WIDTH);

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     diff_ext;
  logic [WIDTH-1:0]   res_d;
  logic               zero_d;
  logic               sign_d;
  logic               carry_d;
  logic               ovf_d;
  logic               accept;

  logic [WIDTH-1:0]   result_q;
  logic               zero_q;
  logic               sign_q;
  logic               carry_q;
  logic               ovf_q;
  logic               out_valid_q;

  assign shamt    = b_i[SHAMT_W-1:0];
  assign sum_ext  = {1'b0, a_i} + {1'b0, b_i};
  assign diff_ext = {1'b0, a_i} - {1'b0, b_i};

  // Single-cycle op mux; reserved codes (and MUL, handled elsewhere) give 0
  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    case (op_i)
      OP_ADD: begin
        res_d   = sum_ext[WIDTH-1:0];
        carry_d = sum_ext[WIDTH];
        ovf_d   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_ext[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        res_d   = diff_ext[WIDTH-1:0];
        carry_d = ~diff_ext[WIDTH];
        ovf_d   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff_ext[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SLL:  res_d = a_i << shamt;
      OP_SRL:  res_d = a_i >> shamt;
      OP_SRA:  res_d = $unsigned($signed(a_i) >>> shamt);
      OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      OP_XOR:  res_d = a_i ^ b_i;
      OP_OR:   res_d = a_i | b_i;
      OP_AND:  res_d = a_i & b_i;
      default: res_d = '0;
    endcase
  end

  assign zero_d = (res_d == '0);
  assign sign_d = res_d[WIDTH-1];

`ifdef ALU_MUL_EN
  state_e           state_q;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  assign in_ready_o = (state_q == ST_IDLE) && (!out_valid_q || out_ready_i);
  assign mul_start  = accept && (op_i == OP_MUL);

  alu_seq_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (mul_start),
    .a_i       (a_i),
    .b_i       (b_i),
    .done_o    (mul_done),
    .product_o (mul_product)
  );
`else
  assign in_ready_o = !out_valid_q || out_ready_i;
`endif

  assign accept = in_valid_i && in_ready_o;

  // Control FSM with registered result/flags; a new write wins over a drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      zero_q      <= 1'b0;
      sign_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ALU_MUL_EN
      state_q     <= ST_IDLE;
`endif
    end else begin
      if (out_valid_q && out_ready_i) begin
        out_valid_q <= 1'b0;
      end
`ifdef ALU_MUL_EN
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (op_i == OP_MUL) begin
              state_q <= ST_MUL;
            end else begin
              result_q    <= res_d;
              zero_q      <= zero_d;
              sign_q      <= sign_d;
              carry_q     <= carry_d;
              ovf_q       <= ovf_d;
              out_valid_q <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          result_q    <= mul_product;
          zero_q      <= (mul_product == '0);
          sign_q      <= mul_product[WIDTH-1];
          carry_q     <= 1'b0;
          ovf_q       <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
`else
      if (accept) begin
        result_q    <= res_d;
        zero_q      <= zero_d;
        sign_q      <= sign_d;
        carry_q     <= carry_d;
        ovf_q       <= ovf_d;
        out_valid_q <= 1'b1;
      end
`endif
    end
  end

  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign zero_o      = zero_q;
  assign sign_o      = sign_q;
  assign carry_o     = carry_q;
  assign ovf_o       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// Module      : tb_alu_seq
// Description : Self-checking bench for alu_seq (WIDTH=32) with a result
//               scoreboard. Follows the ALU_MUL_EN build option of the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        s;
    logic        c;
    logic        v;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  localparam longint MAXS = 64'sh7FFFFFFF;
  localparam longint MINS = -64'sh80000000;

  logic        clk;
  logic        rst_n;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [3:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] result_o;
  logic        zero_o;
  logic        sign_o;
  logic        carry_o;
  logic        ovf_o;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .op_i        (op_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .zero_o      (zero_o),
    .sign_o      (sign_o),
    .carry_o     (carry_o),
    .ovf_o       (ovf_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference behaviour computed with wide integer arithmetic
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa;
    longint      sb;
    longint      s;
    longint      ua;
    longint      ub;
    int          sh;
    e  = '0;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'h0, a};
    ub = {32'h0, b};
    sh = int'(b[4:0]);
    case (op)
      4'h0: begin
        e.r = a + b;
        e.c = (ua + ub) > 64'hFFFFFFFF;
        s   = sa + sb;
        e.v = (s > MAXS) || (s < MINS);
      end
      4'h2: begin
        e.r = a - b;
        e.c = (ua >= ub);
        s   = sa - sb;
        e.v = (s > MAXS) || (s < MINS);
      end
      4'h1: e.r = a << sh;
      4'h5: e.r = a >> sh;
      4'h8: e.r = $unsigned($signed(a) >>> sh);
      4'h3: e.r = (sa < sb) ? 32'd1 : 32'd0;
      4'h9: e.r = (ua < ub) ? 32'd1 : 32'd0;
      4'h4: e.r = a ^ b;
      4'h6: e.r = a | b;
      4'h7: e.r = a & b;
`ifdef ALU_MUL_EN
      4'hA: e.r = a * b;
`endif
      default: e.r = 32'h0;
    endcase
    e.z = (e.r == 32'h0);
    e.s = e.r[31];
    return e;
  endfunction

  // Scoreboard: pop and compare whenever a result handshake is about to occur
  always @(negedge clk) begin
    exp_t ex;
    if (rst_n && out_valid_o && out_ready_i) begin
      checks++;
      n_out++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got r=%h zscv=%b%b%b%b, required no result", result_o, zero_o, sign_o, carry_o, ovf_o);
      end else begin
        ex = sbq.pop_front();
        if ({result_o, zero_o, sign_o, carry_o, ovf_o} !== ex) begin
          errors++;
          $display("FAIL sb_result got r=%h zscv=%b%b%b%b, required r=%h zscv=%b%b%b%b",
                   result_o, zero_o, sign_o, carry_o, ovf_o, ex.r, ex.z, ex.s, ex.c, ex.v);
        end
      end
    end
  end

  // Present one op and hold it until accepted; returns at posedge+1 of the accept edge
  task automatic drive_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int w;
    op_i = op; a_i = a; b_i = b; in_valid_i = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_ready_o && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready_o) begin
      checks++; errors++;
      $display("FAIL accept_timeout got in_ready=0, required 1");
    end else begin
      sbq.push_back(model(op, a, b));
    end
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    op_i = 4'($urandom); a_i = $urandom; b_i = $urandom;
  endtask

  // Count negedges until out_valid rises, and how many of those had in_ready low
  task automatic wait_out(output int k, output int low);
    k = 0; low = 0;
    do begin
      @(negedge clk);
      k++;
      if (!in_ready_o) low++;
    end while (!out_valid_o && k < 100);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    op_i = 4'h0; a_i = 32'h0; b_i = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b required 0", out_valid_o); end
    checks++;
    if (result_o !== 32'h0) begin errors++; $display("FAIL reset_result got %h required 0", result_o); end
    checks++;
    if ({zero_o, sign_o, carry_o, ovf_o} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b%b%b%b required 0000", zero_o, sign_o, carry_o, ovf_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b required 1", in_ready_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_arith();
    vec_t vt[14];
    vt[0]  = '{4'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1010};
    vt[1]  = '{4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0101};
    vt[2]  = '{4'h2, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 4'b0100};
    vt[3]  = '{4'h3, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000};
    vt[4]  = '{4'h9, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1000};
    vt[5]  = '{4'h8, 32'h80000000, 32'h00000024, 32'hF8000000, 4'b0100};
    vt[6]  = '{4'h1, 32'h00000001, 32'h00000021, 32'h00000002, 4'b0000};
    vt[7]  = '{4'h5, 32'h80000000, 32'h0000001F, 32'h00000001, 4'b0000};
    vt[8]  = '{4'h4, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 4'b0000};
    vt[9]  = '{4'h6, 32'h000000F0, 32'h0000000F, 32'h000000FF, 4'b0000};
    vt[10] = '{4'h7, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 4'b0000};
    vt[11] = '{4'hF, 32'h00000005, 32'h00000006, 32'h00000000, 4'b1000};
    vt[12] = '{4'h2, 32'h00000005, 32'h00000005, 32'h00000000, 4'b1010};
    vt[13] = '{4'h2, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011};
    out_ready_i = 1'b1;
    for (int i = 0; i < 14; i++) begin
      drive_op(vt[i].op, vt[i].a, vt[i].b);
      checks++;
      if (out_valid_o !== 1'b1 || {result_o, zero_o, sign_o, carry_o, ovf_o} !== {vt[i].r, vt[i].f}) begin
        errors++;
        $display("FAIL arith_%0d got v=%b r=%h zscv=%b%b%b%b, required v=1 r=%h zscv=%b",
                 i, out_valid_o, result_o, zero_o, sign_o, carry_o, ovf_o, vt[i].r, vt[i].f);
      end
    end
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    int k;
    int low;
    out_ready_i = 1'b1;
`ifdef ALU_MUL_EN
    drive_op(4'hA, 32'd1234, 32'd5678);
    wait_out(k, low);
    checks++;
    if (k != 34 || low != 33) begin
      errors++; $display("FAIL mul_latency got k=%0d low=%0d, required k=34 low=33", k, low);
    end
    checks++;
    if (result_o !== 32'd7006652) begin errors++; $display("FAIL mul_result got %0d required 7006652", result_o); end
    drive_op(4'hA, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_out(k, low);
    checks++;
    if (result_o !== 32'h1 || k != 34) begin
      errors++; $display("FAIL mul_ones got r=%h k=%0d required r=1 k=34", result_o, k);
    end
`else
    drive_op(4'hA, 32'd3, 32'd4);
    checks++;
    if (out_valid_o !== 1'b1 || result_o !== 32'h0 || zero_o !== 1'b1) begin
      errors++; $display("FAIL mul_reserved got v=%b r=%h z=%b required v=1 r=0 z=1", out_valid_o, result_o, zero_o);
    end
    k = 0; low = 0;
`endif
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    out_ready_i = 1'b0;
    drive_op(4'h0, 32'd10, 32'd20);
    in_valid_i = 1'b1; op_i = 4'h0; a_i = 32'd100; b_i = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1 || result_o !== 32'd30) begin
        errors++;
        $display("FAIL bp_hold_%0d got rdy=%b v=%b r=%0d required rdy=0 v=1 r=30", i, in_ready_o, out_valid_o, result_o);
      end
    end
    @(posedge clk); #1;
    out_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready_o !== 1'b1) begin
      errors++; $display("FAIL bp_release got in_ready=%b required 1", in_ready_o);
    end else begin
      sbq.push_back(model(4'h0, 32'd100, 32'd1));
    end
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b1 || result_o !== 32'd101) begin
      errors++; $display("FAIL bp_new got v=%b r=%0d required v=1 r=101", out_valid_o, result_o);
    end
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int n0;
    out_ready_i = 1'b1;
    n0 = n_out;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        in_valid_i = 1'b1; op_i = 4'h0; a_i = 32'(i * 1000 + 7); b_i = $urandom;
      end else begin
        in_valid_i = 1'b0;
      end
      @(negedge clk);
      if (i < 8) begin
        checks++;
        if (in_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d got 0 required 1", i); end
        sbq.push_back(model(4'h0, a_i, b_i));
      end
      if (i > 0) begin
        checks++;
        if (out_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_valid_%0d got 0 required 1", i); end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (n_out - n0 != 8) begin errors++; $display("FAIL b2b_count got %0d required 8", n_out - n0); end
  endtask

  task automatic test_reset_mid();
    int bad;
`ifdef ALU_MUL_EN
    out_ready_i = 1'b1;
    drive_op(4'hA, 32'd7, 32'd9);
    repeat (10) @(negedge clk);
`else
    out_ready_i = 1'b0;
    drive_op(4'h0, 32'd1, 32'd1);
    @(negedge clk);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || result_o !== 32'h0) begin
      errors++; $display("FAIL rst_mid got v=%b r=%h required v=0 r=0", out_valid_o, result_o);
    end
    sbq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready_i = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid_o) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rst_no_result got %0d valid cycles required 0", bad); end
    @(posedge clk); #1;
    drive_op(4'h0, 32'd2, 32'd2);
    checks++;
    if (out_valid_o !== 1'b1 || result_o !== 32'd4) begin
      errors++; $display("FAIL rst_add got v=%b r=%0d required v=1 r=4", out_valid_o, result_o);
    end
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_arith();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d required 0", sbq.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
